systolic_array_ctrl: RTL and testbench

- Sequencer for one SIZE x SIZE weight-stationary array of RPE cells.
- Per job:
  - loads SIZE weight rows from a weight buffer, shifting them downward with weight-valid;
  - streams num_vec activation vectors from an activation buffer;
  - flags, per column, the cycles in which valid partial sums leave the array bottom.
- Sits between the top-level job interface and the array plus its SRAM buffers.

---
 rtl/systolic_array_ctrl.sv | 171 +++++++++++++++++
 tb/tb_systolic_array_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_ctrl.sv
// ============================================================================
// systolic_array_ctrl
// ----------------------------------------------------------------------------
// Job sequencer for one SIZE x SIZE weight-stationary array of RPE cells.
// A job loads SIZE weight rows (bottom row first, so it shifts deepest),
// streams i_num_vec activation vectors, then waits for the last partial sums
// to leave the array bottom before pulsing o_done.
//
// Ports:
//   i_clk              rising-edge clock
//   i_rst_n            synchronous active-low reset
//   i_start            job request, only honoured in IDLE
//   i_num_vec          activation vector count, latched on an accepted start
//   o_busy             high whenever the sequencer is not IDLE
//   o_done             one-cycle pulse at job end
//   o_w_rd_en          weight buffer read enable (1-cycle read latency)
//   o_w_rd_addr        weight row address, SIZE-1 down to 0
//   o_weight_in_valid  weight-load strobe into array row 0
//   o_a_rd_en          activation buffer read enable (1-cycle read latency)
//   o_a_rd_addr        activation vector address, 0 up to num_vec-1
//   o_act_valid        activation data at the array input is valid
//   o_psum_col_valid   bit j: column j bottom partial sum valid this cycle
//
// SIZE must be at least 2.
// ============================================================================
module systolic_array_ctrl #(
    parameter int SIZE  = 8,
    parameter int VEC_W = 16,
    parameter int AW    = $clog2(SIZE)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [VEC_W-1:0] i_num_vec,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_w_rd_en,
    output logic [AW-1:0]    o_w_rd_addr,
    output logic             o_weight_in_valid,
    output logic             o_a_rd_en,
    output logic [VEC_W-1:0] o_a_rd_addr,
    output logic             o_act_valid,
    output logic [SIZE-1:0]  o_psum_col_valid
);

    // Delay line length: column j needs act_valid delayed SIZE+j cycles,
    // and tap k of the line holds act_valid delayed k+1 cycles.
    localparam int DEPTH = 2 * SIZE - 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        COMPUTE,
        DRAIN,
        DONE
    } state_t;

    state_t             r_state;
    logic [VEC_W-1:0]   r_numVec;
    logic               r_busy;
    logic               r_done;
    logic               r_wRdEn;
    logic [AW-1:0]      r_wRdAddr;
    logic               r_weightValid;
    logic               r_aRdEn;
    logic [VEC_W-1:0]   r_aRdAddr;
    logic               r_actValid;
    logic [DEPTH-1:0]   r_delay;
    logic               w_drainPending;

    // DONE must be reached the first cycle in which nothing valid remains,
    // so DRAIN looks one cycle ahead: the valid strobes next cycle are
    // act_valid plus every delay tap except the last one, which is leaving
    // the line this cycle. The read enables are already low in DRAIN.
    always_comb begin
        w_drainPending = r_actValid;
        for (int k = 0; k < DEPTH - 1; k++) begin
            w_drainPending = w_drainPending | r_delay[k];
        end
    end

    // Sequencer FSM with all outputs registered. The valid strobes are the
    // read enables delayed by the buffers' one-cycle read latency, and the
    // psum delay line shifts act_valid so each column's flag matches the
    // diagonal activation skew through the array.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_numVec      <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_wRdEn       <= 1'b0;
            r_wRdAddr     <= '0;
            r_weightValid <= 1'b0;
            r_aRdEn       <= 1'b0;
            r_aRdAddr     <= '0;
            r_actValid    <= 1'b0;
            r_delay       <= '0;
        end else begin
            r_weightValid <= r_wRdEn;
            r_actValid    <= r_aRdEn;
            r_delay       <= {r_delay[DEPTH-2:0], r_actValid};

            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_numVec  <= i_num_vec;
                        r_busy    <= 1'b1;
                        r_wRdEn   <= 1'b1;
                        r_wRdAddr <= AW'(SIZE - 1);
                        r_state   <= LOAD_W;
                    end
                end

                LOAD_W: begin
                    if (r_wRdAddr == '0) begin
                        r_wRdEn <= 1'b0;
                        // An empty job skips COMPUTE entirely.
                        if (r_numVec == '0) begin
                            r_state <= DRAIN;
                        end else begin
                            r_aRdEn   <= 1'b1;
                            r_aRdAddr <= '0;
                            r_state   <= COMPUTE;
                        end
                    end else begin
                        r_wRdAddr <= r_wRdAddr - 1'b1;
                    end
                end

                COMPUTE: begin
                    if (r_aRdAddr == r_numVec - 1'b1) begin
                        r_aRdEn   <= 1'b0;
                        r_aRdAddr <= '0;
                        r_state   <= DRAIN;
                    end else begin
                        r_aRdAddr <= r_aRdAddr + 1'b1;
                    end
                end

                DRAIN: begin
                    if (!w_drainPending) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end

                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign o_w_rd_en         = r_wRdEn;
    assign o_w_rd_addr       = r_wRdAddr;
    assign o_weight_in_valid = r_weightValid;
    assign o_a_rd_en         = r_aRdEn;
    assign o_a_rd_addr       = r_aRdAddr;
    assign o_act_valid       = r_actValid;
    assign o_psum_col_valid  = r_delay[DEPTH-1:SIZE-1];

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// ============================================================================
// tb_systolic_array_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for systolic_array_ctrl (SIZE=8, VEC_W=16). Expected
// outputs for every cycle of a job come from closed-form cycle windows
// measured from the start cycle; per-column psum valid counts are compared
// against the job's vector count.
// ============================================================================
module tb_systolic_array_ctrl;

    localparam int S  = 8;
    localparam int VW = 16;
    localparam int AW = $clog2(S);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [VW-1:0] numVec;
    logic          busy;
    logic          done;
    logic          wRdEn;
    logic [AW-1:0] wRdAddr;
    logic          weightValid;
    logic          aRdEn;
    logic [VW-1:0] aRdAddr;
    logic          actValid;
    logic [S-1:0]  psumValid;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          wEn;
        logic [AW-1:0] wAddr;
        logic          wiv;
        logic          aEn;
        logic [VW-1:0] aAddr;
        logic          av;
        logic [S-1:0]  psum;
    } exp_t;

    systolic_array_ctrl #(
        .SIZE  (S),
        .VEC_W (VW)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_start           (start),
        .i_num_vec         (numVec),
        .o_busy            (busy),
        .o_done            (done),
        .o_w_rd_en         (wRdEn),
        .o_w_rd_addr       (wRdAddr),
        .o_weight_in_valid (weightValid),
        .o_a_rd_en         (aRdEn),
        .o_a_rd_addr       (aRdAddr),
        .o_act_valid       (actValid),
        .o_psum_col_valid  (psumValid)
    );

    always #5 clk = ~clk;

    // Expected outputs t cycles after the start cycle of a job with n vectors.
    function automatic exp_t model(input int t, input int n);
        exp_t e;
        int   doneT;
        e     = '0;
        doneT = (n == 0) ? S + 2 : 3 * S + n + 1;
        e.busy  = (t >= 1) && (t <= doneT);
        e.done  = (t == doneT);
        e.wEn   = (t >= 1) && (t <= S);
        e.wAddr = e.wEn ? AW'(S - t) : '0;
        e.wiv   = (t >= 2) && (t <= S + 1);
        e.aEn   = (t >= S + 1) && (t <= S + n);
        e.aAddr = e.aEn ? VW'(t - S - 1) : '0;
        e.av    = (t >= S + 2) && (t <= S + n + 1);
        for (int j = 0; j < S; j++) begin
            e.psum[j] = (t >= 2 * S + 2 + j) && (t <= 2 * S + 1 + j + n);
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string where, input exp_t e);
        checkOutput({where, " busy"},  32'(busy),        32'(e.busy));
        checkOutput({where, " done"},  32'(done),        32'(e.done));
        checkOutput({where, " wEn"},   32'(wRdEn),       32'(e.wEn));
        checkOutput({where, " wAddr"}, 32'(wRdAddr),     32'(e.wAddr));
        checkOutput({where, " wiv"},   32'(weightValid), 32'(e.wiv));
        checkOutput({where, " aEn"},   32'(aRdEn),       32'(e.aEn));
        checkOutput({where, " aAddr"}, 32'(aRdAddr),     32'(e.aAddr));
        checkOutput({where, " av"},    32'(actValid),    32'(e.av));
        checkOutput({where, " psum"},  32'(psumValid),   32'(e.psum));
        checkOutput({where, " overlap"}, 32'(weightValid & actValid), 32'(0));
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [VW-1:0] n);
        start  = s;
        numVec = n;
    endtask

    // Runs one job from the current cycle (cycle 0) through the idle cycle
    // after done. num_vec is scrambled after the start cycle to show it is
    // latched; start can be held or re-pulsed to show it is ignored.
    task automatic runJob(input int n, input bit hold, input int pulseAt);
        int doneT;
        int cnt[S];
        doneT = (n == 0) ? S + 2 : 3 * S + n + 1;
        foreach (cnt[j]) cnt[j] = 0;
        applyStimulus(1'b1, VW'(n));
        for (int t = 1; t <= doneT + 1; t++) begin
            stepCycle();
            applyStimulus((hold && t <= doneT) || (t == pulseAt), VW'($urandom));
            checkAll($sformatf("n=%0d t=%0d", n, t), model(t, n));
            for (int j = 0; j < S; j++) cnt[j] += int'(psumValid[j]);
        end
        for (int j = 0; j < S; j++) begin
            checkOutput($sformatf("popcount n=%0d col%0d", n, j), 32'(cnt[j]), 32'(n));
        end
    endtask

    initial begin
        int n;

        // Reset state
        rst_n = 1'b0;
        applyStimulus(1'b1, VW'(5));
        stepCycle();
        stepCycle();
        checkAll("reset", '0);
        rst_n = 1'b1;
        applyStimulus(1'b0, '0);
        stepCycle();
        checkAll("idle", '0);

        // Reference job, empty job, held start, mid-COMPUTE re-pulse
        runJob(4, 1'b0, 0);
        runJob(0, 1'b0, 0);
        runJob(5, 1'b1, 0);
        runJob(6, 1'b0, S + 3);
        stepCycle();
        checkAll("no queued job a", '0);
        stepCycle();
        checkAll("no queued job b", '0);

        // Reset for one cycle during COMPUTE aborts the job
        applyStimulus(1'b1, VW'(10));
        for (int t = 1; t <= S + 3; t++) begin
            stepCycle();
            applyStimulus(1'b0, VW'($urandom));
            checkAll($sformatf("pre-abort t=%0d", t), model(t, 10));
        end
        rst_n = 1'b0;
        stepCycle();
        rst_n = 1'b1;
        checkAll("abort", '0);
        for (int k = 0; k < 4; k++) begin
            stepCycle();
            checkAll($sformatf("after abort %0d", k), '0);
        end
        runJob(7, 1'b0, 0);

        // Long job exercising contiguous addresses
        runJob(300, 1'b0, 0);

        // Randomized jobs
        for (int r = 0; r < 5; r++) begin
            n = int'($urandom_range(0, 24));
            runJob(n, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3 * S + n)));
            stepCycle();
            checkAll($sformatf("random %0d idle", r), '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
